// File: rtl/zap_alu_main_if.sv
// Operand bundle from the shift stage into the ALU and the ALU's result and memory-request outputs.
interface zap_alu_main_if #(
  parameter int PHY_REGS = 46,
  parameter int ALU_OPS  = 32
);
  localparam int IDX_W = $clog2(PHY_REGS);
  localparam int OP_W  = $clog2(ALU_OPS);

  logic [3:0]       i_condition_code_ff;
  logic [OP_W-1:0]  i_alu_operation_ff;
  logic             i_flag_update_ff;
  logic [IDX_W-1:0] i_destination_index_ff;
  logic [31:0]      i_alu_source_value_ff;
  logic [31:0]      i_shifted_source_value_ff;
  logic             i_shift_carry_ff;
  logic             i_rrx_ff;
  logic             i_mem_load_ff;
  logic             i_mem_store_ff;
  logic             i_mem_pre_index_ff;
  logic [IDX_W-1:0] i_mem_srcdest_index_ff;
  logic [31:0]      i_mem_srcdest_value_ff;
  logic [31:0]      i_pc_plus_8_ff;

  logic [31:0]      o_alu_value_nxt;
  logic             o_clear_from_alu;
  logic [31:0]      o_pc_from_alu;
  logic [31:0]      o_alu_result_ff;
  logic [IDX_W-1:0] o_destination_index_ff;
  logic             o_dav_ff;
  logic [3:0]       o_flags_ff;
  logic [31:0]      o_mem_address_ff;
  logic             o_mem_load_ff;
  logic             o_mem_store_ff;
  logic [IDX_W-1:0] o_mem_srcdest_index_ff;
  logic [31:0]      o_mem_srcdest_value_ff;
  logic [31:0]      o_pc_plus_8_ff;

  modport slave (
    input  i_condition_code_ff, i_alu_operation_ff, i_flag_update_ff, i_destination_index_ff,
           i_alu_source_value_ff, i_shifted_source_value_ff, i_shift_carry_ff, i_rrx_ff,
           i_mem_load_ff, i_mem_store_ff, i_mem_pre_index_ff, i_mem_srcdest_index_ff,
           i_mem_srcdest_value_ff, i_pc_plus_8_ff,
    output o_alu_value_nxt, o_clear_from_alu, o_pc_from_alu, o_alu_result_ff,
           o_destination_index_ff, o_dav_ff, o_flags_ff, o_mem_address_ff, o_mem_load_ff,
           o_mem_store_ff, o_mem_srcdest_index_ff, o_mem_srcdest_value_ff, o_pc_plus_8_ff
  );

  modport master (
    output i_condition_code_ff, i_alu_operation_ff, i_flag_update_ff, i_destination_index_ff,
           i_alu_source_value_ff, i_shifted_source_value_ff, i_shift_carry_ff, i_rrx_ff,
           i_mem_load_ff, i_mem_store_ff, i_mem_pre_index_ff, i_mem_srcdest_index_ff,
           i_mem_srcdest_value_ff, i_pc_plus_8_ff,
    input  o_alu_value_nxt, o_clear_from_alu, o_pc_from_alu, o_alu_result_ff,
           o_destination_index_ff, o_dav_ff, o_flags_ff, o_mem_address_ff, o_mem_load_ff,
           o_mem_store_ff, o_mem_srcdest_index_ff, o_mem_srcdest_value_ff, o_pc_plus_8_ff
  );
endinterface

// File: rtl/zap_alu_main.sv
// Execute stage: condition check against NZCV, data-processing ALU, load/store address
// generation and taken-branch flush back to the shift stage.
module zap_alu_main #(
  parameter int PHY_REGS = 46,
  parameter int ALU_OPS  = 32,
  parameter int PC_INDEX = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear_from_writeback,
  input  logic       i_data_stall,
  input  logic       i_restore_flags,
  input  logic [3:0] i_flags_writeback,
  zap_alu_main_if.slave bus
);
  localparam int IDX_W = $clog2(PHY_REGS);
  localparam int OP_W  = $clog2(ALU_OPS);

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } alu_op_e;

  logic [31:0]      result_q, result_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic             dav_q, dav_d;
  logic [3:0]       flags_q, flags_d;
  logic [31:0]      addr_q, addr_d;
  logic             load_q, load_d;
  logic             store_q, store_d;
  logic [IDX_W-1:0] sd_idx_q, sd_idx_d;
  logic [31:0]      sd_val_q, sd_val_d;
  logic [31:0]      pc8_q, pc8_d;

  alu_op_e     op;
  logic [31:0] op_a, op_b, res;
  logic [31:0] add_x, add_y;
  logic        add_cin, is_arith, is_test, cond_pass, exec, writes_reg, is_mem, branch;
  logic [32:0] sum;
  logic        flg_n, flg_z, flg_c, flg_v;
  logic [3:0]  flags_new;

  assign flg_n = flags_q[3];
  assign flg_z = flags_q[2];
  assign flg_c = flags_q[1];
  assign flg_v = flags_q[0];

  always_comb begin
    cond_pass = 1'b0;
    case (bus.i_condition_code_ff)
      4'h0: cond_pass = flg_z;
      4'h1: cond_pass = !flg_z;
      4'h2: cond_pass = flg_c;
      4'h3: cond_pass = !flg_c;
      4'h4: cond_pass = flg_n;
      4'h5: cond_pass = !flg_n;
      4'h6: cond_pass = flg_v;
      4'h7: cond_pass = !flg_v;
      4'h8: cond_pass = flg_c && !flg_z;
      4'h9: cond_pass = !flg_c || flg_z;
      4'hA: cond_pass = (flg_n == flg_v);
      4'hB: cond_pass = (flg_n != flg_v);
      4'hC: cond_pass = !flg_z && (flg_n == flg_v);
      4'hD: cond_pass = flg_z || (flg_n != flg_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    // Undefined opcodes above 15 execute as MOV.
    op   = (bus.i_alu_operation_ff > OP_W'(15)) ? OP_MOV : alu_op_e'(bus.i_alu_operation_ff[3:0]);
    op_a = bus.i_alu_source_value_ff;
    op_b = bus.i_rrx_ff ? {flg_c, bus.i_shifted_source_value_ff[30:0]}
                        : bus.i_shifted_source_value_ff;
    add_x    = op_a;
    add_y    = op_b;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    res      = op_b;
    case (op)
      OP_AND, OP_TST: res = op_a & op_b;
      OP_EOR, OP_TEQ: res = op_a ^ op_b;
      OP_ORR:         res = op_a | op_b;
      OP_BIC:         res = op_a & ~op_b;
      OP_MVN:         res = ~op_b;
      OP_SUB, OP_CMP: begin is_arith = 1'b1; add_y = ~op_b; add_cin = 1'b1; end
      OP_RSB:         begin is_arith = 1'b1; add_x = op_b; add_y = ~op_a; add_cin = 1'b1; end
      OP_ADD, OP_CMN: begin is_arith = 1'b1; end
      OP_ADC:         begin is_arith = 1'b1; add_cin = flg_c; end
      OP_SBC:         begin is_arith = 1'b1; add_y = ~op_b; add_cin = flg_c; end
      OP_RSC:         begin is_arith = 1'b1; add_x = op_b; add_y = ~op_a; add_cin = flg_c; end
      default:        res = op_b;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    if (is_arith) res = sum[31:0];

    flags_new[3] = res[31];
    flags_new[2] = (res == 32'd0);
    flags_new[1] = is_arith ? sum[32] : bus.i_shift_carry_ff;
    flags_new[0] = is_arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : flg_v;

    is_test    = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    is_mem     = bus.i_mem_load_ff || bus.i_mem_store_ff;
    exec       = cond_pass;
    writes_reg = is_mem || !is_test;
    branch     = exec && writes_reg && (bus.i_destination_index_ff == IDX_W'(PC_INDEX))
                 && !bus.i_mem_load_ff;
  end

  assign bus.o_alu_value_nxt  = res;
  assign bus.o_pc_from_alu    = res;
  assign bus.o_clear_from_alu = branch && !i_data_stall && !i_clear_from_writeback;

  always_comb begin
    result_d = result_q;
    dest_d   = dest_q;
    dav_d    = dav_q;
    flags_d  = flags_q;
    addr_d   = addr_q;
    load_d   = load_q;
    store_d  = store_q;
    sd_idx_d = sd_idx_q;
    sd_val_d = sd_val_q;
    pc8_d    = pc8_q;
    if (i_clear_from_writeback) begin
      result_d = '0;
      dest_d   = '0;
      dav_d    = 1'b0;
      addr_d   = '0;
      load_d   = 1'b0;
      store_d  = 1'b0;
      sd_idx_d = '0;
      sd_val_d = '0;
      pc8_d    = '0;
      if (i_restore_flags) flags_d = i_flags_writeback;
    end else if (!i_data_stall) begin
      // A taken branch is captured like any other instruction; upstream flush handles the rest.
      result_d = res;
      dest_d   = bus.i_destination_index_ff;
      dav_d    = exec && writes_reg;
      addr_d   = bus.i_mem_pre_index_ff ? res : op_a;
      load_d   = exec && bus.i_mem_load_ff;
      store_d  = exec && bus.i_mem_store_ff;
      sd_idx_d = bus.i_mem_srcdest_index_ff;
      sd_val_d = bus.i_mem_srcdest_value_ff;
      pc8_d    = bus.i_pc_plus_8_ff;
      if (exec && bus.i_flag_update_ff) flags_d = flags_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      result_q <= '0;
      dest_q   <= '0;
      dav_q    <= 1'b0;
      flags_q  <= '0;
      addr_q   <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      sd_idx_q <= '0;
      sd_val_q <= '0;
      pc8_q    <= '0;
    end else begin
      result_q <= result_d;
      dest_q   <= dest_d;
      dav_q    <= dav_d;
      flags_q  <= flags_d;
      addr_q   <= addr_d;
      load_q   <= load_d;
      store_q  <= store_d;
      sd_idx_q <= sd_idx_d;
      sd_val_q <= sd_val_d;
      pc8_q    <= pc8_d;
    end
  end

  assign bus.o_alu_result_ff        = result_q;
  assign bus.o_destination_index_ff = dest_q;
  assign bus.o_dav_ff               = dav_q;
  assign bus.o_flags_ff             = flags_q;
  assign bus.o_mem_address_ff       = addr_q;
  assign bus.o_mem_load_ff          = load_q;
  assign bus.o_mem_store_ff         = store_q;
  assign bus.o_mem_srcdest_index_ff = sd_idx_q;
  assign bus.o_mem_srcdest_value_ff = sd_val_q;
  assign bus.o_pc_plus_8_ff         = pc8_q;
endmodule

// File: tb/tb_zap_alu_main.sv
// Vector-table and hand-sequence bench for zap_alu_main with a result scoreboard queue.
module tb_zap_alu_main;
  logic       clk = 1'b0;
  logic       rst;
  logic       clr_wb, stall, restore;
  logic [3:0] flags_wb;

  zap_alu_main_if #(.PHY_REGS(46), .ALU_OPS(32)) bus ();

  zap_alu_main #(.PHY_REGS(46), .ALU_OPS(32), .PC_INDEX(15)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr_wb), .i_data_stall(stall),
    .i_restore_flags(restore), .i_flags_writeback(flags_wb), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [4:0]  op;
    logic        s;
    logic [5:0]  dest;
    logic [31:0] a, b;
    logic        sc, rrx, ld, st, pre;
    logic [31:0] e_res;
    logic        e_dav;
    logic [3:0]  e_flags;
    logic [31:0] e_addr;
    logic        e_ld, e_st;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dav;
    logic [3:0]  flags;
    logic [31:0] addr;
    logic        ld, st;
    logic [5:0]  dest;
    logic [31:0] pc8;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [4:0] op, input logic s,
                       input logic [5:0] dest, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic rrx, input logic ld, input logic st,
                       input logic pre, input logic [31:0] pc8);
    bus.i_condition_code_ff       = cond;
    bus.i_alu_operation_ff        = op;
    bus.i_flag_update_ff          = s;
    bus.i_destination_index_ff    = dest;
    bus.i_alu_source_value_ff     = a;
    bus.i_shifted_source_value_ff = b;
    bus.i_shift_carry_ff          = sc;
    bus.i_rrx_ff                  = rrx;
    bus.i_mem_load_ff             = ld;
    bus.i_mem_store_ff            = st;
    bus.i_mem_pre_index_ff        = pre;
    bus.i_mem_srcdest_index_ff    = 6'd7;
    bus.i_mem_srcdest_value_ff    = 32'hCAFE0000 | pc8;
    bus.i_pc_plus_8_ff            = pc8;
  endtask

  task automatic check_regs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " result"}, bus.o_alu_result_ff, e.res);
    chk({tag, " dav"}, 32'(bus.o_dav_ff), 32'(e.dav));
    chk({tag, " flags"}, 32'(bus.o_flags_ff), 32'(e.flags));
    chk({tag, " addr"}, bus.o_mem_address_ff, e.addr);
    chk({tag, " load"}, 32'(bus.o_mem_load_ff), 32'(e.ld));
    chk({tag, " store"}, 32'(bus.o_mem_store_ff), 32'(e.st));
    chk({tag, " dest"}, 32'(bus.o_destination_index_ff), 32'(e.dest));
    chk({tag, " pc8"}, bus.o_pc_plus_8_ff, e.pc8);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    //          cond  op     s     dest  a             b             sc    rrx   ld    st    pre   res           dav   flags    addr          ld    st
    vecs[0]  = '{4'hE, 5'd4,  1'b1, 6'd2, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b1, 4'b1001, 32'h7FFFFFFF, 1'b0, 1'b0};
    vecs[1]  = '{4'hE, 5'd10, 1'b1, 6'd0, 32'h5,        32'h5,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0110, 32'h5,        1'b0, 1'b0};
    vecs[2]  = '{4'h0, 5'd13, 1'b0, 6'd1, 32'h0,        32'hAB,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAB,       1'b1, 4'b0110, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{4'h1, 5'd13, 1'b0, 6'd1, 32'h0,        32'hAB,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAB,       1'b0, 4'b0110, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{4'hE, 5'd13, 1'b0, 6'd5, 32'h0,        32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000002, 1'b1, 4'b0110, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{4'hE, 5'd4,  1'b0, 6'd3, 32'h1000,     32'h4,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1004,     1'b1, 4'b0110, 32'h1004,     1'b1, 1'b0};
    vecs[6]  = '{4'hE, 5'd4,  1'b0, 6'd3, 32'h1000,     32'h4,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1004,     1'b1, 4'b0110, 32'h1000,     1'b1, 1'b0};
    vecs[7]  = '{4'h1, 5'd4,  1'b0, 6'd3, 32'h2000,     32'h8,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008,     1'b0, 4'b0110, 32'h2008,     1'b0, 1'b0};
    vecs[8]  = '{4'hE, 5'd2,  1'b1, 6'd4, 32'h0,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 4'b1000, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{4'hB, 5'd12, 1'b1, 6'd4, 32'hF0,       32'h0F,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF,       1'b1, 4'b0010, 32'hF0,       1'b0, 1'b0};
    vecs[10] = '{4'hC, 5'd15, 1'b1, 6'd4, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 4'b1000, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{4'hF, 5'd4,  1'b1, 6'd4, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,        1'b0, 4'b1000, 32'h1,        1'b0, 1'b0};
    vecs[12] = '{4'hE, 5'd6,  1'b1, 6'd4, 32'h5,        32'h3,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,        1'b1, 4'b0010, 32'h5,        1'b0, 1'b0};
    vecs[13] = '{4'hE, 5'd7,  1'b1, 6'd4, 32'h3,        32'h5,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,        1'b1, 4'b0010, 32'h3,        1'b0, 1'b0};
    vecs[14] = '{4'hE, 5'd5,  1'b1, 6'd4, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[15] = '{4'hE, 5'd20, 1'b0, 6'd6, 32'h9,        32'h1234,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234,     1'b1, 4'b0110, 32'h9,        1'b0, 1'b0};
    vecs[16] = '{4'hE, 5'd9,  1'b1, 6'd6, 32'hF,        32'hF,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0100, 32'hF,        1'b0, 1'b0};
    vecs[17] = '{4'h8, 5'd11, 1'b1, 6'd6, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,        1'b0, 4'b0100, 32'h1,        1'b0, 1'b0};

    rst = 1'b1; clr_wb = 1'b0; stall = 1'b0; restore = 1'b0; flags_wb = 4'h0;
    drive(4'hF, 5'd13, 1'b0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    chk("reset result", bus.o_alu_result_ff, 32'h0);
    chk("reset flags", 32'(bus.o_flags_ff), 32'h0);
    chk("reset dav", 32'(bus.o_dav_ff), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].cond, vecs[i].op, vecs[i].s, vecs[i].dest, vecs[i].a, vecs[i].b,
            vecs[i].sc, vecs[i].rrx, vecs[i].ld, vecs[i].st, vecs[i].pre, 32'h100 + 32'(i));
      #1;
      chk($sformatf("vec%0d nxt", i), bus.o_alu_value_nxt, vecs[i].e_res);
      e = '{vecs[i].e_res, vecs[i].e_dav, vecs[i].e_flags, vecs[i].e_addr,
            vecs[i].e_ld, vecs[i].e_st, vecs[i].dest, 32'h100 + 32'(i)};
      sb.push_back(e);
      tick();
      check_regs($sformatf("vec%0d", i));
    end

    // Taken branch: MOV pc <- 0x100.
    @(negedge clk);
    drive(4'hE, 5'd13, 1'b0, 6'd15, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
    #1;
    chk("br clear", 32'(bus.o_clear_from_alu), 32'h1);
    chk("br pc", bus.o_pc_from_alu, 32'h100);
    sb.push_back('{32'h100, 1'b1, 4'b0100, 32'h0, 1'b0, 1'b0, 6'd15, 32'h400});
    tick();
    check_regs("br");

    // Same branch under stall: no flush, everything (flags included) holds.
    @(negedge clk);
    stall = 1'b1;
    drive(4'hE, 5'd13, 1'b1, 6'd15, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500);
    #1;
    chk("brstall clear", 32'(bus.o_clear_from_alu), 32'h0);
    chk("brstall nxt", bus.o_alu_value_nxt, 32'h200);
    sb.push_back('{32'h100, 1'b1, 4'b0100, 32'h0, 1'b0, 1'b0, 6'd15, 32'h400});
    tick();
    check_regs("brstall");

    // Writeback clear while stalled, restoring NZCV.
    @(negedge clk);
    clr_wb = 1'b1; restore = 1'b1; flags_wb = 4'b0110;
    #1;
    chk("wbclr clear", 32'(bus.o_clear_from_alu), 32'h0);
    sb.push_back('{32'h0, 1'b0, 4'b0110, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0});
    tick();
    check_regs("wbclr");
    chk("wbclr sdval", bus.o_mem_srcdest_value_ff, 32'h0);

    // Restored Z=1 must let MOVEQ execute.
    @(negedge clk);
    clr_wb = 1'b0; restore = 1'b0; stall = 1'b0;
    drive(4'h0, 5'd13, 1'b0, 6'd1, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600);
    sb.push_back('{32'h55, 1'b1, 4'b0110, 32'h0, 1'b0, 1'b0, 6'd1, 32'h600});
    tick();
    check_regs("moveq");

    // Load into PC is not an ALU branch.
    @(negedge clk);
    drive(4'hE, 5'd4, 1'b0, 6'd15, 32'h3000, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700);
    #1;
    chk("ldpc clear", 32'(bus.o_clear_from_alu), 32'h0);
    sb.push_back('{32'h3010, 1'b1, 4'b0110, 32'h3010, 1'b1, 1'b0, 6'd15, 32'h700});
    tick();
    check_regs("ldpc");
    chk("ldpc sdidx", 32'(bus.o_mem_srcdest_index_ff), 32'd7);

    // Reset mid-operation.
    @(negedge clk);
    rst = 1'b1;
    drive(4'hE, 5'd4, 1'b1, 6'd4, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h800);
    sb.push_back('{32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0});
    tick();
    check_regs("rst");
    chk("rst sdval", bus.o_mem_srcdest_value_ff, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
